// File: rtl/ramb_s4_arbiter.sv
// ramb_s4_arbiter: shares one single-port block RAM between requesters A and B.
// Arbitration is round-robin. A clear engine can fill the whole RAM with FILL_VAL.
//
// Ports:
//   CLK, RST_N                 clock; synchronous active-low reset
//   REQ_x/WE_x/ADDR_x/DI_x     requester x access (held until GNT_x)
//   GNT_x                      combinational grant, at most one per cycle
//   RVALID_x/RDATA_x           read response, one cycle after a read grant
//   CLR_START/CLR_BUSY/CLR_DONE  clear engine control and status
//   RAM_EN/WE/SSR/ADDR/DI      drive the RAM primitive; RAM_DO comes back from it
module ramb_s4_arbiter #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 4,
  parameter int                DEPTH    = 4096,
  parameter logic [DATA_W-1:0] FILL_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_A,
  input  logic              WE_A,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [DATA_W-1:0] DI_A,
  output logic              GNT_A,
  output logic              RVALID_A,
  output logic [DATA_W-1:0] RDATA_A,
  input  logic              REQ_B,
  input  logic              WE_B,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic [DATA_W-1:0] DI_B,
  output logic              GNT_B,
  output logic              RVALID_B,
  output logic [DATA_W-1:0] RDATA_B,
  input  logic              CLR_START,
  output logic              CLR_BUSY,
  output logic              CLR_DONE,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic              RAM_SSR,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DI,
  input  logic [DATA_W-1:0] RAM_DO
);

  typedef enum logic {RUN, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              last_b, last_b_nxt;  // 1: B was granted most recently
  logic              rvalid_a, rvalid_b, clr_done;
  logic              gnt_a, gnt_b;

  // RAM strobes are held off while reset is asserted so a sweep stops
  // writing in the same cycle reset arrives.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_b_nxt = last_b;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    RAM_EN     = 1'b0;
    RAM_WE     = 1'b0;
    RAM_ADDR   = '0;
    RAM_DI     = '0;
    if (RST_N) begin
      unique case (state)
        RUN: begin
          if (CLR_START) begin
            cnt_nxt   = '0;
            state_nxt = CLEAR;
          end else begin
            gnt_a = REQ_A & (~REQ_B | last_b);
            gnt_b = REQ_B & (~REQ_A | ~last_b);
            if (gnt_a) begin
              RAM_EN     = 1'b1;
              RAM_WE     = WE_A;
              RAM_ADDR   = ADDR_A;
              RAM_DI     = DI_A;
              last_b_nxt = 1'b0;
            end else if (gnt_b) begin
              RAM_EN     = 1'b1;
              RAM_WE     = WE_B;
              RAM_ADDR   = ADDR_B;
              RAM_DI     = DI_B;
              last_b_nxt = 1'b1;
            end
          end
        end
        CLEAR: begin
          RAM_EN   = 1'b1;
          RAM_WE   = 1'b1;
          RAM_ADDR = cnt;
          RAM_DI   = FILL_VAL;
          cnt_nxt  = cnt + 1'b1;
          if (cnt == LAST_ADDR) state_nxt = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= RUN;
      cnt      <= '0;
      last_b   <= 1'b1;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_b   <= last_b_nxt;
      rvalid_a <= gnt_a & ~WE_A;
      rvalid_b <= gnt_b & ~WE_B;
      clr_done <= (state == CLEAR) && (cnt == LAST_ADDR);
    end
  end

  assign GNT_A    = gnt_a;
  assign GNT_B    = gnt_b;
  assign RVALID_A = rvalid_a;
  assign RVALID_B = rvalid_b;
  // RAM_DO is valid exactly in the cycle after the read, so gate rather than register.
  assign RDATA_A  = rvalid_a ? RAM_DO : '0;
  assign RDATA_B  = rvalid_b ? RAM_DO : '0;
  assign CLR_BUSY = (state == CLEAR);
  assign CLR_DONE = clr_done;
  assign RAM_SSR  = 1'b0;

endmodule

// File: tb/tb_ramb_s4_arbiter.sv
// Bench for ramb_s4_arbiter: table of single-cycle arbitration vectors plus
// hand-written clear / reset sequences; read data is checked via a scoreboard.
module tb_ramb_s4_arbiter;
  localparam int         AW    = 12;
  localparam int         DW    = 4;
  localparam int         DEPTH = 4096;
  localparam logic [3:0] FILL  = 4'h0;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          REQ_A, WE_A, REQ_B, WE_B;
  logic [AW-1:0] ADDR_A, ADDR_B;
  logic [DW-1:0] DI_A, DI_B;
  logic          GNT_A, GNT_B, RVALID_A, RVALID_B;
  logic [DW-1:0] RDATA_A, RDATA_B;
  logic          CLR_START, CLR_BUSY, CLR_DONE;
  logic          RAM_EN, RAM_WE, RAM_SSR;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_DI;
  logic [DW-1:0] RAM_DO;

  ramb_s4_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .FILL_VAL(FILL)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_A(REQ_A), .WE_A(WE_A), .ADDR_A(ADDR_A), .DI_A(DI_A), .GNT_A(GNT_A),
    .RVALID_A(RVALID_A), .RDATA_A(RDATA_A),
    .REQ_B(REQ_B), .WE_B(WE_B), .ADDR_B(ADDR_B), .DI_B(DI_B), .GNT_B(GNT_B),
    .RVALID_B(RVALID_B), .RDATA_B(RDATA_B),
    .CLR_START(CLR_START), .CLR_BUSY(CLR_BUSY), .CLR_DONE(CLR_DONE),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_SSR(RAM_SSR),
    .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
  );

  always #5 CLK = ~CLK;

  // Behavioural 4096x4 single-port RAM, synchronous read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (RAM_EN) begin
      if (RAM_WE) mem[RAM_ADDR] <= RAM_DI;
      else        RAM_DO <= mem[RAM_ADDR];
    end
  end

  typedef struct {
    logic          req_a, we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] di_a;
    logic          req_b, we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] di_b;
    logic          e_ga, e_gb, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_di;
  } vec_t;

  typedef struct {
    bit            is_b;
    logic [DW-1:0] data;
  } rsp_t;

  int            checks = 0;
  int            errors = 0;
  rsp_t          sb[$];
  logic [DW-1:0] ref_mem [DEPTH];
  vec_t          tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t idle_v();
    vec_t v;
    v.req_a = 1'b0; v.we_a = 1'b0; v.addr_a = '0; v.di_a = '0;
    v.req_b = 1'b0; v.we_b = 1'b0; v.addr_b = '0; v.di_b = '0;
    v.e_ga = 1'b0; v.e_gb = 1'b0; v.e_we = 1'b0; v.e_addr = '0; v.e_di = '0;
    return v;
  endfunction

  function automatic vec_t acc_a(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    vec_t v = idle_v();
    v.req_a = 1'b1; v.we_a = we; v.addr_a = a; v.di_a = d;
    v.e_ga = 1'b1; v.e_we = we; v.e_addr = a; v.e_di = d;
    return v;
  endfunction

  function automatic vec_t acc_b(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    vec_t v = idle_v();
    v.req_b = 1'b1; v.we_b = we; v.addr_b = a; v.di_b = d;
    v.e_gb = 1'b1; v.e_we = we; v.e_addr = a; v.e_di = d;
    return v;
  endfunction

  task automatic drive_idle();
    REQ_A = 1'b0; WE_A = 1'b0; ADDR_A = '0; DI_A = '0;
    REQ_B = 1'b0; WE_B = 1'b0; ADDR_B = '0; DI_B = '0;
    CLR_START = 1'b0;
  endtask

  // Pop the expected response (if any) and compare both RVALIDs and RDATA.
  task automatic chk_rsp(input string tag);
    rsp_t r;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk({tag, "/rvalid_a"}, 32'(RVALID_A), 32'(!r.is_b));
      chk({tag, "/rvalid_b"}, 32'(RVALID_B), 32'(r.is_b));
      chk({tag, "/rdata"}, 32'(r.is_b ? RDATA_B : RDATA_A), 32'(r.data));
    end else begin
      chk({tag, "/rvalid_a_idle"}, 32'(RVALID_A), 32'd0);
      chk({tag, "/rvalid_b_idle"}, 32'(RVALID_B), 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(posedge CLK); #1;
    REQ_A = v.req_a; WE_A = v.we_a; ADDR_A = v.addr_a; DI_A = v.di_a;
    REQ_B = v.req_b; WE_B = v.we_b; ADDR_B = v.addr_b; DI_B = v.di_b;
    CLR_START = 1'b0;
    @(negedge CLK);
    chk_rsp(tag);
    chk({tag, "/gnt_a"}, 32'(GNT_A), 32'(v.e_ga));
    chk({tag, "/gnt_b"}, 32'(GNT_B), 32'(v.e_gb));
    chk({tag, "/ram_en"}, 32'(RAM_EN), 32'(v.e_ga | v.e_gb));
    chk({tag, "/ram_we"}, 32'(RAM_WE), 32'(v.e_we));
    chk({tag, "/ram_addr"}, 32'(RAM_ADDR), 32'(v.e_addr));
    chk({tag, "/ram_di"}, 32'(RAM_DI), 32'(v.e_di));
    if (v.e_ga) begin
      if (v.we_a) ref_mem[v.addr_a] = v.di_a;
      else        sb.push_back('{1'b0, ref_mem[v.addr_a]});
    end
    if (v.e_gb) begin
      if (v.we_b) ref_mem[v.addr_b] = v.di_b;
      else        sb.push_back('{1'b1, ref_mem[v.addr_b]});
    end
  endtask

  // Full clear; optional CLR_START re-pulse and optional B read of 0x010 raised mid-sweep.
  task automatic run_clear(input int restart_at, input int breq_at, input string tag);
    int busy = 0;
    int bad  = 0;
    @(posedge CLK); #1;
    drive_idle();
    CLR_START = 1'b1;
    @(negedge CLK);
    chk({tag, "/start_en"}, 32'(RAM_EN), 32'd0);
    chk({tag, "/start_busy"}, 32'(CLR_BUSY), 32'd0);
    @(posedge CLK); #1;
    CLR_START = 1'b0;
    for (int c = 0; c < DEPTH + 16; c++) begin
      CLR_START = (c == restart_at);
      if (c == breq_at) begin
        REQ_B = 1'b1; WE_B = 1'b0; ADDR_B = 12'h010; DI_B = '0;
      end
      @(negedge CLK);
      if (!CLR_BUSY) break;
      if (RAM_EN !== 1'b1 || RAM_WE !== 1'b1 || RAM_ADDR !== 12'(c) || RAM_DI !== FILL ||
          GNT_A !== 1'b0 || GNT_B !== 1'b0 || CLR_DONE !== 1'b0)
        bad++;
      busy++;
      @(posedge CLK); #1;
    end
    CLR_START = 1'b0;
    chk({tag, "/busy_cycles"}, 32'(busy), 32'(DEPTH));
    chk({tag, "/sweep_bad_cycles"}, 32'(bad), 32'd0);
    chk({tag, "/clr_done"}, 32'(CLR_DONE), 32'd1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = FILL;
    if (breq_at >= 0) begin
      chk({tag, "/gnt_b_first_run"}, 32'(GNT_B), 32'd1);
      chk({tag, "/gnt_a_first_run"}, 32'(GNT_A), 32'd0);
      chk({tag, "/addr_first_run"}, 32'(RAM_ADDR), 32'h010);
      sb.push_back('{1'b1, ref_mem[12'h010]});
    end
    @(posedge CLK); #1;
    drive_idle();
    @(negedge CLK);
    chk_rsp({tag, "/after"});
    chk({tag, "/done_pulse_end"}, 32'(CLR_DONE), 32'd0);
    chk({tag, "/busy_end"}, 32'(CLR_BUSY), 32'd0);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int dones;
    drive_idle();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("rst/rvalid_a", 32'(RVALID_A), 32'd0);
    chk("rst/rvalid_b", 32'(RVALID_B), 32'd0);
    chk("rst/rdata_a", 32'(RDATA_A), 32'd0);
    chk("rst/rdata_b", 32'(RDATA_B), 32'd0);
    chk("rst/clr_busy", 32'(CLR_BUSY), 32'd0);
    chk("rst/clr_done", 32'(CLR_DONE), 32'd0);
    chk("rst/ram_en", 32'(RAM_EN), 32'd0);
    chk("rst/ram_we", 32'(RAM_WE), 32'd0);
    chk("rst/ram_ssr", 32'(RAM_SSR), 32'd0);

    // Pointer starts at "B last": first tie goes to A, then alternates.
    tbl.push_back(acc_a(1'b1, 12'h005, 4'hA));
    tbl.push_back(acc_a(1'b0, 12'h005, 4'h1));
    tbl.push_back(acc_b(1'b1, 12'h010, 4'h3));
    tbl.push_back('{1'b1, 1'b1, 12'h020, 4'h7, 1'b1, 1'b0, 12'h010, 4'h2,
                    1'b1, 1'b0, 1'b1, 12'h020, 4'h7});
    tbl.push_back('{1'b1, 1'b0, 12'h020, 4'h1, 1'b1, 1'b0, 12'h010, 4'h2,
                    1'b0, 1'b1, 1'b0, 12'h010, 4'h2});
    tbl.push_back('{1'b1, 1'b0, 12'h020, 4'h1, 1'b1, 1'b0, 12'h005, 4'h2,
                    1'b1, 1'b0, 1'b0, 12'h020, 4'h1});
    tbl.push_back('{1'b1, 1'b0, 12'h005, 4'h1, 1'b1, 1'b0, 12'h005, 4'h2,
                    1'b0, 1'b1, 1'b0, 12'h005, 4'h2});
    tbl.push_back('{1'b1, 1'b0, 12'h010, 4'h1, 1'b1, 1'b0, 12'h020, 4'h2,
                    1'b1, 1'b0, 1'b0, 12'h010, 4'h1});
    tbl.push_back(idle_v());
    tbl.push_back(acc_b(1'b1, 12'h005, 4'h5));
    tbl.push_back(acc_a(1'b0, 12'h005, 4'h0));
    tbl.push_back(acc_a(1'b0, 12'h010, 4'h0));
    tbl.push_back(acc_b(1'b0, 12'h020, 4'h0));
    tbl.push_back(acc_a(1'b1, 12'hFFF, 4'hC));
    tbl.push_back(idle_v());
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    run_clear(-1, 10, "clr1");
    run_vec(acc_a(1'b0, 12'hFFF, 4'h0), "rd_fff");
    run_vec(idle_v(), "rd_fff_rsp");

    run_clear(50, -1, "clr2");

    // Reset with a read being granted: the response must not appear.
    @(posedge CLK); #1;
    REQ_A = 1'b1; WE_A = 1'b0; ADDR_A = 12'h005; RST_N = 1'b0;
    @(posedge CLK); #1;
    drive_idle(); RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_rd/rvalid_a", 32'(RVALID_A), 32'd0);
    chk("rst_rd/rdata_a", 32'(RDATA_A), 32'd0);
    run_vec('{1'b1, 1'b0, 12'h005, 4'h1, 1'b1, 1'b0, 12'h010, 4'h2,
              1'b1, 1'b0, 1'b0, 12'h005, 4'h1}, "rst_ptr");
    run_vec(idle_v(), "rst_ptr_rsp");

    // Reset at clear cycle 100.
    run_vec(acc_a(1'b1, 12'd50, 4'h6), "pre_w50");
    run_vec(acc_a(1'b1, 12'd99, 4'h5), "pre_w99");
    run_vec(acc_a(1'b1, 12'd200, 4'h9), "pre_w200");
    @(posedge CLK); #1;
    drive_idle(); CLR_START = 1'b1;
    @(posedge CLK); #1;
    CLR_START = 1'b0;
    repeat (100) @(posedge CLK);
    #1 RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("mid_rst/clr_busy", 32'(CLR_BUSY), 32'd0);
    chk("mid_rst/clr_done", 32'(CLR_DONE), 32'd0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (CLR_DONE === 1'b1 || CLR_BUSY === 1'b1) dones++;
    end
    chk("mid_rst/no_done_later", 32'(dones), 32'd0);
    for (int i = 0; i < 100; i++) ref_mem[i] = FILL;
    run_vec(acc_a(1'b0, 12'd50, 4'h0), "mid_rd50");
    run_vec(acc_a(1'b0, 12'd99, 4'h0), "mid_rd99");
    run_vec(acc_a(1'b0, 12'd200, 4'h0), "mid_rd200");
    run_vec(idle_v(), "mid_rsp");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ramb_s4_arbiter.md
Name: ramb_s4_arbiter

Overview:
- Shares one 4096x4 single-port block RAM (synchronous read, 1-cycle latency, 12-bit address, 4-bit data) between two requesters, A and B.
- Arbitration is round-robin.
- Contains a clear engine that fills the whole RAM with a constant.
- Sits between the RAM primitive and two client blocks. The client blocks never drive the RAM directly.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 4, RAM data width.
- DEPTH, 4096, number of words swept by a clear (2**ADDR_W).
- FILL_VAL, 4'h0, data written to every word during a clear.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  synchronous, active-low reset.
- REQ_A  in  1  requester A access request; held until granted.
- WE_A  in  1  A: 1 = write, 0 = read.
- ADDR_A  in  ADDR_W  A address.
- DI_A  in  DATA_W  A write data.
- GNT_A  out  1  A granted this cycle (combinational).
- RVALID_A  out  1  A read data valid.
- RDATA_A  out  DATA_W  A read data.
- REQ_B / WE_B / ADDR_B / DI_B / GNT_B / RVALID_B / RDATA_B: same as the A ports, for requester B.
- CLR_START  in  1  single-cycle pulse; starts a clear.
- CLR_BUSY  out  1  clear in progress.
- CLR_DONE  out  1  single-cycle pulse after the last clear write.
- RAM_EN  out  1  to RAM EN.
- RAM_WE  out  1  to RAM WE.
- RAM_SSR  out  1  to RAM SSR; constant 0.
- RAM_ADDR  out  ADDR_W  to RAM ADDR.
- RAM_DI  out  DATA_W  to RAM DI.
- RAM_DO  in  DATA_W  from RAM DO.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is synchronous, active-low.
- Reset values:
  - State = RUN.
  - Clear counter = 0.
  - Priority pointer = "B last", so A wins the first tie.
  - RVALID_A = RVALID_B = 0; RDATA_A = RDATA_B = 0.
  - CLR_BUSY = 0; CLR_DONE = 0.
  - RAM_EN/RAM_WE are combinational and therefore 0 in reset.
- States: RUN and CLEAR.
- RUN, no CLR_START:
  - At most one grant per cycle; GNT_A and GNT_B are one-hot or zero.
  - Only one requester active: it is granted.
  - Both active: the requester not granted most recently is granted. The pointer updates on every grant.
  - Granted requester's WE/ADDR/DI drive the RAM combinationally, with RAM_EN = 1.
  - No grant: RAM_EN = 0, RAM_WE = 0, RAM_ADDR and RAM_DI = 0.
- Read response:
  - A granted read (WE = 0) at edge N sets that requester's RVALID at edge N+1 for exactly one cycle.
  - While RVALID is high, RDATA = RAM_DO (registered capture is not needed; pass-through is gated).
  - Granted writes never produce RVALID.
  - Back-to-back grants give back-to-back RVALIDs: full throughput, 1 access per cycle.
- RUN with CLR_START = 1:
  - No grants that cycle; RAM_EN = 0.
  - Counter is loaded with 0; next state is CLEAR.
  - CLR_START has priority over requests.
- CLEAR:
  - Every cycle: RAM_EN = 1, RAM_WE = 1, RAM_ADDR = counter, RAM_DI = FILL_VAL; counter increments.
  - CLR_BUSY = 1 in every CLEAR cycle.
  - After the write at counter = DEPTH-1 (counter wraps to 0), next state is RUN, and CLR_DONE pulses for one cycle in the first RUN cycle.
  - A clear occupies exactly DEPTH cycles.
  - GNT_A = GNT_B = 0 throughout. Requests stay pending and are arbitrated normally from the first RUN cycle, which is the same cycle CLR_DONE is high.
  - CLR_START during CLEAR is ignored; it does not restart the sweep.
- Read-during-write: the arbiter does not forward data. The RAM is single-port, so a read and a write can never share a cycle.
- Reset mid-clear: the sweep aborts immediately; state returns to RUN with reset values; no CLR_DONE.
- Reset with a read outstanding: the pending RVALID is suppressed.
- RAM_SSR is always 0.

Test Plan:
- After reset, A only: REQ_A = 1, WE_A = 1, ADDR_A = 12'h005, DI_A = 4'hA for one cycle. Then A read of 12'h005 -> GNT_A in both cycles; RAM_WE = 1, then RAM_WE = 0; RVALID_A one cycle after the read grant with RDATA_A = 4'hA.
- Contention: REQ_A and REQ_B both held high for 4 cycles, all reads -> grants alternate A, B, A, B; RVALIDs alternate A, B, A, B, each lagging its grant by one cycle; never both GNTs high.
- Clear: CLR_START pulse -> CLR_BUSY high for exactly 4096 cycles; RAM_ADDR sweeps 0 to 4095 with RAM_WE = 1 and RAM_DI = 0; CLR_DONE one cycle later. A subsequent read of addr 12'hFFF returns 4'h0.
- Request during clear: REQ_B read of 12'h010 asserted 10 cycles into a clear -> no GNT_B until the first RUN cycle, where GNT_B = 1 in the same cycle as CLR_DONE; RVALID_B the next cycle.
- Reset mid-clear: RST_N = 0 for one cycle at clear cycle 100 -> CLR_BUSY = 0 next cycle; no CLR_DONE; addresses 0..99 hold FILL_VAL, address 200 keeps its prior value.
- CLR_START repeated at clear cycle 50 -> ignored; total clear length remains 4096 cycles; exactly one CLR_DONE.
